seg_time_decoder: RTL and testbench
===================================

SEG_TIME_DECODER -- requirements
Module: seg_time_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2, the number of cycles a frame must stay unchanged before acceptance (legal 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports segh1, segh2  input  7 each  hour tens/units pattern {a,b,c,d,e,f,g}, active-high.
REQ-005 SHALL have ports segm1, segm2  input  7 each  minute tens/units pattern.
REQ-006 SHALL have ports segs1, segs2  input  7 each  second tens/units pattern.
REQ-007 SHALL have ports hours, mins, secs  output  6 each  binary time (0-23, 0-59, 0-59).
REQ-008 SHALL have port time_valid  output  1  high while hours/mins/secs hold a legal decoded time.
REQ-009 SHALL have port tick  output  1  one-cycle pulse when a new, different legal time is accepted.
REQ-010 SHALL have port dec_err  output  1  level, high while the last accepted frame is illegal.
REQ-011 SHALL have port seq_err  output  1  one-cycle pulse on a time-continuity violation (see Configuration).

Function
REQ-012 SHALL register all six 7-bit inputs (42-bit frame) every cycle in a capture stage.
REQ-013 SHALL compare the captured frame with the previous captured frame each cycle; on mismatch it SHALL clear the stability counter, otherwise increment it, saturating at STABLE_CYCLES.
REQ-014 SHALL accept a frame exactly once, on the cycle the counter reaches STABLE_CYCLES; a frame change inside the window SHALL restart the count with no partial output update.
REQ-015 SHALL decode digits as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; any other pattern SHALL be illegal.
REQ-016 SHALL treat a frame as illegal if any digit is illegal, hour tens >2, hours >23, or minute/second tens >5.
REQ-017 SHALL convert each field as tens*10+units in 6 bits, without overflow for legal frames.
REQ-018 On acceptance of a legal frame it SHALL load hours/mins/secs, set time_valid=1 and dec_err=0, and pulse tick only if the time differs from the held time.
REQ-019 On acceptance of an illegal frame it SHALL hold hours/mins/secs, set time_valid=0 and dec_err=1, and SHALL NOT pulse tick.
REQ-020 Outputs SHALL update exactly STABLE_CYCLES+2 rising edges after the edge that first captures a new frame held constant throughout.

Reset
REQ-021 While reset=0 at a clock edge: hours=mins=secs=0, time_valid=0, dec_err=0, tick=0, seq_err=0, capture/previous registers all-zero, counter 0.
REQ-022 Reset mid-window SHALL discard the pending frame; the first capture after release SHALL count as a new frame.

Configuration
REQ-023 With SEG_TIME_DECODER_SEQ_CHECK_EN defined, each accepted legal frame differing from the held legal time SHALL pulse seq_err together with tick unless it equals held+1 s (wrap 59 s->0 carry minutes, 59 min->0 carry hours, 23:59:59->00:00:00); the first legal time after reset or after an illegal frame SHALL NOT be checked.
REQ-024 Without the macro, seq_err SHALL be tied 0 and no continuity logic synthesised.

Structure
REQ-025 Package seg_time_pkg SHALL hold the ten digit patterns, SEG_W=7, TIME_W=6, MAX_HOUR=23, MAX_MINSEC=59.
REQ-026 Sub-module seg_to_bcd (combinational, pattern -> 4-bit digit + legal flag) SHALL be instantiated six times.

Verification
REQ-027 Reset released, frame 12:34:56 held -> at edge STABLE_CYCLES+2 after capture: hours=12, mins=34, secs=56, time_valid=1, tick one pulse.
REQ-028 Frame 00:00:07 with secs units changed to 0000001 -> dec_err=1, time_valid=0, prior time held, no tick.
REQ-029 Frame 25:00:00 (legal patterns) -> dec_err=1; then 23:00:00 -> hours=23, dec_err=0, tick.
REQ-030 Frame toggled every cycle for 10 cycles (STABLE_CYCLES=2) -> no output change; then held -> accepted after 4 edges.
REQ-031 With macro: 23:59:59 then 00:00:00 -> tick, no seq_err; 10:00:00 then 10:00:05 -> tick and seq_err pulse.
REQ-032 reset=0 asserted 1 cycle before acceptance -> all outputs 0, no tick; same frame accepted STABLE_CYCLES+2 edges after release.

Source files
------------

// File: rtl/seg_time_pkg.sv
// Shared types and constants for the seven-segment time decoder.
package seg_time_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned TIME_W     = 6;
  localparam int unsigned DIG_W      = 4;
  localparam int unsigned MAX_HOUR   = 23;
  localparam int unsigned MAX_MINSEC = 59;

  // Digit patterns, bit order {a,b,c,d,e,f,g}, active-high
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

  typedef struct packed {
    logic [SEG_W-1:0] h1;
    logic [SEG_W-1:0] h2;
    logic [SEG_W-1:0] m1;
    logic [SEG_W-1:0] m2;
    logic [SEG_W-1:0] s1;
    logic [SEG_W-1:0] s2;
  } seg_frame_t;

  typedef struct packed {
    logic [TIME_W-1:0] hours;
    logic [TIME_W-1:0] mins;
    logic [TIME_W-1:0] secs;
  } hms_t;

  // One second later, wrapping 23:59:59 to 00:00:00
  function automatic hms_t time_inc(input hms_t t);
    hms_t r;
    r = t;
    if (t.secs != TIME_W'(MAX_MINSEC)) begin
      r.secs = t.secs + TIME_W'(1);
    end else begin
      r.secs = '0;
      if (t.mins != TIME_W'(MAX_MINSEC)) begin
        r.mins = t.mins + TIME_W'(1);
      end else begin
        r.mins  = '0;
        r.hours = (t.hours == TIME_W'(MAX_HOUR)) ? '0 : t.hours + TIME_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational seven-segment pattern to decimal digit decoder.
module seg_to_bcd
  import seg_time_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [DIG_W-1:0] digit_c,
  output logic             legal_c
);

  // Map each legal pattern to its digit; anything else is flagged illegal
  always_comb begin
    digit_c = '0;
    legal_c = 1'b1;
    case (seg)
      SEG_0:   digit_c = DIG_W'(0);
      SEG_1:   digit_c = DIG_W'(1);
      SEG_2:   digit_c = DIG_W'(2);
      SEG_3:   digit_c = DIG_W'(3);
      SEG_4:   digit_c = DIG_W'(4);
      SEG_5:   digit_c = DIG_W'(5);
      SEG_6:   digit_c = DIG_W'(6);
      SEG_7:   digit_c = DIG_W'(7);
      SEG_8:   digit_c = DIG_W'(8);
      SEG_9:   digit_c = DIG_W'(9);
      default: legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_time_decoder.sv
// Seven-segment clock display decoder: captures a six-digit frame, waits for
// it to be stable, then decodes it to binary hours/minutes/seconds.
// Optional continuity checker enabled by SEG_TIME_DECODER_SEQ_CHECK_EN.
module seg_time_decoder
  import seg_time_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEG_W-1:0]  segh1,
  input  logic [SEG_W-1:0]  segh2,
  input  logic [SEG_W-1:0]  segm1,
  input  logic [SEG_W-1:0]  segm2,
  input  logic [SEG_W-1:0]  segs1,
  input  logic [SEG_W-1:0]  segs2,
  output logic [TIME_W-1:0] hours,
  output logic [TIME_W-1:0] mins,
  output logic [TIME_W-1:0] secs,
  output logic              time_valid,
  output logic              tick,
  output logic              dec_err,
  output logic              seq_err
);

  localparam int unsigned       CNT_W   = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

  seg_frame_t        frame_c;
  seg_frame_t        cap_q;
  seg_frame_t        prev_q;
  logic              cap_vld_q;
  logic              prev_vld_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              same_c;
  logic              accept_c;

  logic [SEG_W-1:0]  pat_c   [6];
  logic [DIG_W-1:0]  dig_c   [6];
  logic [5:0]        leg_c;
  hms_t              dec_c;
  logic              legal_c;

  logic              acc_q;
  logic              legal_q;
  hms_t              dec_q;
  hms_t              held_c;
  logic              differs_c;

  assign frame_c = {segh1, segh2, segm1, segm2, segs1, segs2};

  // The valid flags keep the reset contents of the capture pair from looking
  // like a stable frame, so the first capture after reset always starts fresh.
  assign same_c   = prev_vld_q && (cap_q == prev_q);
  assign accept_c = same_c && (cnt_q == CNT_PRE);

  // Capture stage and stability counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_q      <= '0;
      prev_q     <= '0;
      cap_vld_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      cap_q      <= frame_c;
      prev_q     <= cap_q;
      cap_vld_q  <= 1'b1;
      prev_vld_q <= cap_vld_q;
      if (!same_c) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pat_c[0] = cap_q.h1;
  assign pat_c[1] = cap_q.h2;
  assign pat_c[2] = cap_q.m1;
  assign pat_c[3] = cap_q.m2;
  assign pat_c[4] = cap_q.s1;
  assign pat_c[5] = cap_q.s2;

  for (genvar gi = 0; gi < 6; gi++) begin : g_dig
    seg_to_bcd u_dig (
      .seg     (pat_c[gi]),
      .digit_c (dig_c[gi]),
      .legal_c (leg_c[gi])
    );
  end

  // Field conversion and range checks on the captured frame
  always_comb begin
    dec_c       = '0;
    dec_c.hours = TIME_W'(dig_c[0]) * TIME_W'(10) + TIME_W'(dig_c[1]);
    dec_c.mins  = TIME_W'(dig_c[2]) * TIME_W'(10) + TIME_W'(dig_c[3]);
    dec_c.secs  = TIME_W'(dig_c[4]) * TIME_W'(10) + TIME_W'(dig_c[5]);
    legal_c     = (&leg_c)
                  && (dig_c[0] <= DIG_W'(2))
                  && (dec_c.hours <= TIME_W'(MAX_HOUR))
                  && (dig_c[2] <= DIG_W'(5))
                  && (dig_c[4] <= DIG_W'(5));
  end

  // Decode register: latches the frame on the acceptance cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q   <= 1'b0;
      legal_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      acc_q <= accept_c;
      if (accept_c) begin
        legal_q <= legal_c;
        dec_q   <= dec_c;
      end
    end
  end

  assign held_c    = {hours, mins, secs};
  assign differs_c = (dec_q != held_c);

  // Output stage: load legal time or flag an illegal frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      hours      <= '0;
      mins       <= '0;
      secs       <= '0;
      time_valid <= 1'b0;
      dec_err    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (acc_q) begin
        if (legal_q) begin
          hours      <= dec_q.hours;
          mins       <= dec_q.mins;
          secs       <= dec_q.secs;
          time_valid <= 1'b1;
          dec_err    <= 1'b0;
          tick       <= differs_c;
        end else begin
          time_valid <= 1'b0;
          dec_err    <= 1'b1;
        end
      end
    end
  end

`ifdef SEG_TIME_DECODER_SEQ_CHECK_EN
  // Continuity: a new legal time following a legal time must be held + 1 s
  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_err <= 1'b0;
    end else begin
      seq_err <= acc_q && legal_q && differs_c && time_valid
                 && (dec_q != time_inc(held_c));
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_time_decoder.sv
// Self-checking bench for seg_time_decoder: vector table plus reset and
// frame-toggling sequences, expectations queued as stimulus is driven.
module tb_seg_time_decoder;

  localparam int unsigned S = 2;
`ifdef SEG_TIME_DECODER_SEQ_CHECK_EN
  localparam int SEQ_EN = 1;
`else
  localparam int SEQ_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] segh1, segh2, segm1, segm2, segs1, segs2;
  logic [5:0] hours, mins, secs;
  logic       time_valid, tick, dec_err, seq_err;

  always #5 clk = ~clk;

  seg_time_decoder #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .segh1      (segh1),
    .segh2      (segh2),
    .segm1      (segm1),
    .segm2      (segm2),
    .segs1      (segs1),
    .segs2      (segs2),
    .hours      (hours),
    .mins       (mins),
    .secs       (secs),
    .time_valid (time_valid),
    .tick       (tick),
    .dec_err    (dec_err),
    .seq_err    (seq_err)
  );

  typedef struct {
    int h; int m; int s; int v; int e; int t; int q;
  } exp_t;

  typedef struct {
    int h; int m; int s;
    int bad_pos; logic [6:0] bad_pat;
    int eh; int em; int es; int ev; int ee; int et; int eq;
  } vec_t;

  exp_t sb[$];
  exp_t held;
  exp_t zero_exp;
  vec_t vecs[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [41:0] mk(input int h, input int m, input int s);
    return {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10), seg_of(m % 10),
            seg_of(s / 10), seg_of(s % 10)};
  endfunction

  task automatic drive(input logic [41:0] f);
    {segh1, segh2, segm1, segm2, segs1, segs2} = f;
  endtask

  task automatic cmp(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t x);
    cmp({tag, " hours"},      int'(hours),      x.h);
    cmp({tag, " mins"},       int'(mins),       x.m);
    cmp({tag, " secs"},       int'(secs),       x.s);
    cmp({tag, " time_valid"}, int'(time_valid), x.v);
    cmp({tag, " dec_err"},    int'(dec_err),    x.e);
    cmp({tag, " tick"},       int'(tick),       x.t);
    cmp({tag, " seq_err"},    int'(seq_err),    x.q * SEQ_EN);
  endtask

  // Drive a frame, expect no change until S+2 edges after capture, then x
  task automatic run_frame(input string tag, input logic [41:0] f, input exp_t x);
    exp_t got;
    @(negedge clk);
    drive(f);
    sb.push_back(x);
    for (int k = 0; k <= int'(S) + 1; k++) begin
      @(posedge clk); #1;
      check_outs($sformatf("%s wait%0d", tag, k), held);
    end
    @(posedge clk); #1;
    got = sb.pop_front();
    check_outs({tag, " accept"}, got);
    held   = got;
    held.t = 0;
    held.q = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_outs($sformatf("%s steady%0d", tag, k), held);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [41:0] f;
    logic [41:0] fa;
    logic [41:0] fb;
    exp_t        x;

    //            h  m  s  pos pat       eh em es ev ee et eq
    vecs[0]  = '{12,34,56, -1, 7'h00,    12,34,56, 1, 0, 1, 0};
    vecs[1]  = '{12,34,57, -1, 7'h00,    12,34,57, 1, 0, 1, 0};
    vecs[2]  = '{ 0, 0, 7,  5, 7'b0000001, 12,34,57, 0, 1, 0, 0};
    vecs[3]  = '{25, 0, 0, -1, 7'h00,    12,34,57, 0, 1, 0, 0};
    vecs[4]  = '{23, 0, 0, -1, 7'h00,    23, 0, 0, 1, 0, 1, 0};
    vecs[5]  = '{23,59,59, -1, 7'h00,    23,59,59, 1, 0, 1, 1};
    vecs[6]  = '{ 0, 0, 0, -1, 7'h00,     0, 0, 0, 1, 0, 1, 0};
    vecs[7]  = '{10, 0, 0, -1, 7'h00,    10, 0, 0, 1, 0, 1, 1};
    vecs[8]  = '{10, 0, 5, -1, 7'h00,    10, 0, 5, 1, 0, 1, 1};
    vecs[9]  = '{ 9,59,59, -1, 7'h00,     9,59,59, 1, 0, 1, 1};
    vecs[10] = '{10, 0, 0, -1, 7'h00,    10, 0, 0, 1, 0, 1, 0};
    vecs[11] = '{ 8,60, 0, -1, 7'h00,    10, 0, 0, 0, 1, 0, 0};
    vecs[12] = '{10, 0, 0, -1, 7'h00,    10, 0, 0, 1, 0, 0, 0};
    vecs[13] = '{19,59,59, -1, 7'h00,    19,59,59, 1, 0, 1, 1};
    vecs[14] = '{20, 0, 0, -1, 7'h00,    20, 0, 0, 1, 0, 1, 0};
    vecs[15] = '{24, 0, 0, -1, 7'h00,    20, 0, 0, 0, 1, 0, 0};
    vecs[16] = '{12,34,56,  0, 7'h00,    20, 0, 0, 0, 1, 0, 0};
    vecs[17] = '{ 0, 0, 1, -1, 7'h00,     0, 0, 1, 1, 0, 1, 0};

    zero_exp = '{0, 0, 0, 0, 0, 0, 0};
    held     = zero_exp;

    // Reset state
    reset = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", zero_exp);
    @(negedge clk);
    reset = 1'b1;

    // Table of frames
    foreach (vecs[i]) begin
      f = mk(vecs[i].h, vecs[i].m, vecs[i].s);
      if (vecs[i].bad_pos >= 0) f[41 - 7 * vecs[i].bad_pos -: 7] = vecs[i].bad_pat;
      x = '{vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ev, vecs[i].ee, vecs[i].et, vecs[i].eq};
      run_frame($sformatf("vec%0d", i), f, x);
    end

    // Frame changing every cycle never gets accepted; then held one is
    fa = mk(11, 11, 11);
    fb = mk(22, 22, 22);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive((i % 2 == 0) ? fa : fb);
      @(posedge clk); #1;
      check_outs($sformatf("toggle%0d", i), held);
    end
    run_frame("toggle_hold", fb, '{22, 22, 22, 1, 0, 1, 1});

    // Reset one cycle before acceptance discards the pending frame
    f = mk(5, 6, 7);
    @(negedge clk);
    drive(f);
    for (int k = 0; k <= int'(S); k++) begin
      @(posedge clk); #1;
      check_outs($sformatf("rst_pre%0d", k), held);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_outs("rst_asserted", zero_exp);
    @(negedge clk);
    reset = 1'b1;
    held = zero_exp;
    sb.push_back('{5, 6, 7, 1, 0, 1, 0});
    for (int k = 0; k <= int'(S) + 1; k++) begin
      @(posedge clk); #1;
      check_outs($sformatf("rst_post%0d", k), held);
    end
    @(posedge clk); #1;
    x = sb.pop_front();
    check_outs("rst_accept", x);
    held   = x;
    held.t = 0;
    held.q = 0;
    @(posedge clk); #1;
    check_outs("rst_steady", held);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
